// File: rtl/sprite_scheduler_pkg.sv
// Shared types and constants for the sprite scheduler: FSM state encoding,
// the queued request record, and a small elaboration-time helper.
package sprite_scheduler_pkg;

    // Widest coordinate / sprite-id the request record can carry.
    localparam int CORDW_MAX   = 10;
    localparam int SPR_IDW_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_ARM     = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } sched_state_t;

    // One queued sprite: top-left position and ROM bank index.
    typedef struct packed {
        logic [CORDW_MAX-1:0]   x;
        logic [CORDW_MAX-1:0]   y;
        logic [SPR_IDW_MAX-1:0] id;
    } spr_req_t;

    localparam int REQ_W = $bits(spr_req_t);

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sprite_scheduler_if.sv
// Request, renderer and status signals of the sprite scheduler, bundled.
// master = the side that issues requests and hosts the renderer,
// slave  = the scheduler itself.
interface sprite_scheduler_if
    import sprite_scheduler_pkg::*;
#(
    parameter int CORDW   = CORDW_MAX,
    parameter int SPR_IDW = SPR_IDW_MAX
) ();

    logic               frame_start;
    logic               req_valid;
    logic               req_ready;
    logic [CORDW-1:0]   req_x;
    logic [CORDW-1:0]   req_y;
    logic [SPR_IDW-1:0] req_id;

    logic               spr_rst;
    logic               spr_enable;
    logic [CORDW-1:0]   spr_sx;
    logic [CORDW-1:0]   spr_sy;
    logic [SPR_IDW-1:0] spr_id;
    logic               spr_drawing;

    logic               busy;
    logic               frame_done;
    logic               err_overrun;
    logic               err_wdog;

    modport master (
        output frame_start, req_valid, req_x, req_y, req_id, spr_drawing,
        input  req_ready, spr_rst, spr_enable, spr_sx, spr_sy, spr_id,
        input  busy, frame_done, err_overrun, err_wdog
    );

    modport slave (
        input  frame_start, req_valid, req_x, req_y, req_id, spr_drawing,
        output req_ready, spr_rst, spr_enable, spr_sx, spr_sy, spr_id,
        output busy, frame_done, err_overrun, err_wdog
    );

endinterface

// File: rtl/sprite_req_fifo.sv
// Small synchronous FIFO for pending sprite requests. The head word is read
// asynchronously so the scheduler can pop and latch it in the same cycle;
// at these depths the storage maps to distributed RAM.
module sprite_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // A full FIFO never takes a word, even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_reg == DEPTH_CNT);
    assign empty   = (count_reg == '0);
    assign dout    = mem[rd_ptr_reg];

    // Storage write; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite scheduler: queues sprite requests and, once a frame is opened,
// feeds them one at a time to an external renderer (reset pulse, enable,
// wait for the drawing flag to rise and fall), with a watchdog on the rise.
module sprite_scheduler
    import sprite_scheduler_pkg::*;
#(
    parameter int SPR_WIDTH  = 8,
    parameter int SPR_HEIGHT = 8,
    parameter int CORDW      = 10,
    parameter int SPR_IDW    = 4,
    parameter int QDEPTH     = 4,
    parameter int WDOG       = 4
) (
    input  logic               clk,
    input  logic               rst,
    sprite_scheduler_if.slave  bus
);

    // Parameter sanity checks at elaboration. SPR_WIDTH/SPR_HEIGHT describe
    // the renderer attached to the spr_* port and are only validated here.
    generate
        if (!is_pow2(QDEPTH) || (QDEPTH < 2)) begin : g_bad_qdepth
            $error("sprite_scheduler: QDEPTH must be a power of two >= 2");
        end
        if ((SPR_WIDTH < 1) || (SPR_HEIGHT < 1)) begin : g_bad_spr_size
            $error("sprite_scheduler: sprite dimensions must be positive");
        end
        if ((CORDW > CORDW_MAX) || (SPR_IDW > SPR_IDW_MAX)) begin : g_bad_width
            $error("sprite_scheduler: CORDW/SPR_IDW exceed request record width");
        end
        if (WDOG < 1) begin : g_bad_wdog
            $error("sprite_scheduler: WDOG must be at least 1");
        end
    endgenerate

    localparam int WDW = $clog2(WDOG + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG - 1);

    sched_state_t       state_reg;
    sched_state_t       state_next;

    spr_req_t           req_word;
    spr_req_t           head_word;
    logic               fifo_full;
    logic               fifo_empty;
    logic               req_ready;
    logic               push;
    logic               pop;

    logic               frame_active_reg;
    logic               err_overrun_reg;
    logic               err_wdog_reg;
    logic [CORDW-1:0]   spr_sx_reg;
    logic [CORDW-1:0]   spr_sy_reg;
    logic [SPR_IDW-1:0] spr_id_reg;
    logic [WDW-1:0]     wdog_cnt_reg;

    logic               wdog_expired;
    logic               spr_rst_c;
    logic               spr_enable_c;
    logic               frame_done_c;
    logic               wdog_clr;
    logic               wdog_inc;
    logic               wdog_fire;

    // Request side: ready simply mirrors free space, and is held low in reset.
    assign req_ready = !rst && !fifo_full;
    assign push      = bus.req_valid && req_ready;
    assign req_word  = '{x:  CORDW_MAX'(bus.req_x),
                         y:  CORDW_MAX'(bus.req_y),
                         id: SPR_IDW_MAX'(bus.req_id)};

    sprite_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (req_word),
        .pop   (pop),
        .dout  (head_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The watchdog has reached its limit on the last allowed WAIT_HI cycle.
    assign wdog_expired = (wdog_cnt_reg == WDOG_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one sprite per pass through CLR/ARM/WAIT_HI/WAIT_LO.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (frame_active_reg && !fifo_empty) begin
                    state_next = ST_CLR;
                end
            end
            ST_CLR:  state_next = ST_ARM;
            ST_ARM:  state_next = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (bus.spr_drawing) begin
                    state_next = ST_WAIT_LO;
                end else if (wdog_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!bus.spr_drawing) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs; reset forces the renderer into reset and kills the enable.
    always_comb begin
        spr_rst_c    = rst;
        spr_enable_c = 1'b0;
        pop          = 1'b0;
        frame_done_c = 1'b0;
        wdog_clr     = 1'b0;
        wdog_inc     = 1'b0;
        wdog_fire    = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: begin
                    if (frame_active_reg) begin
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            frame_done_c = 1'b1;
                        end
                    end
                end
                ST_CLR: spr_rst_c = 1'b1;
                ST_ARM: begin
                    spr_enable_c = 1'b1;
                    wdog_clr     = 1'b1;
                end
                ST_WAIT_HI: begin
                    spr_enable_c = 1'b1;
                    if (!bus.spr_drawing) begin
                        if (wdog_expired) begin
                            wdog_fire = 1'b1;
                        end else begin
                            wdog_inc = 1'b1;
                        end
                    end
                end
                ST_WAIT_LO: spr_enable_c = 1'b1;
                default: ;
            endcase
        end
    end

    // Frame bookkeeping and sticky error flags; a repeated frame_start is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_active_reg <= 1'b0;
            err_overrun_reg  <= 1'b0;
            err_wdog_reg     <= 1'b0;
        end else begin
            if (bus.frame_start && frame_active_reg) begin
                err_overrun_reg <= 1'b1;
            end
            if (frame_done_c) begin
                frame_active_reg <= 1'b0;
            end else if (bus.frame_start) begin
                frame_active_reg <= 1'b1;
            end
            if (wdog_fire) begin
                err_wdog_reg <= 1'b1;
            end
        end
    end

    // Latch the popped head; it stays put until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            spr_sx_reg <= '0;
            spr_sy_reg <= '0;
            spr_id_reg <= '0;
        end else if (pop) begin
            spr_sx_reg <= head_word.x[CORDW-1:0];
            spr_sy_reg <= head_word.y[CORDW-1:0];
            spr_id_reg <= head_word.id[SPR_IDW-1:0];
        end
    end

    // Watchdog: cleared in ARM, counts WAIT_HI cycles without drawing.
    always_ff @(posedge clk) begin
        if (rst || wdog_clr) begin
            wdog_cnt_reg <= '0;
        end else if (wdog_inc) begin
            wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.spr_rst     = spr_rst_c;
    assign bus.spr_enable  = spr_enable_c;
    assign bus.spr_sx      = spr_sx_reg;
    assign bus.spr_sy      = spr_sy_reg;
    assign bus.spr_id      = spr_id_reg;
    assign bus.busy        = (state_reg != ST_IDLE) || frame_active_reg;
    assign bus.frame_done  = frame_done_c;
    assign bus.err_overrun = err_overrun_reg;
    assign bus.err_wdog    = err_wdog_reg;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler. Inputs change and outputs are sampled
// on the falling clock edge. A simple renderer model raises drawing on the
// second enabled cycle and holds it for 64 cycles, or never when rend_dead.
module tb_sprite_scheduler;

    localparam int CW  = 10;
    localparam int IW  = 4;
    localparam int LIM = 300;

    logic clk;
    logic rst;
    logic rend_dead    = 1'b0;
    logic rend_drawing = 1'b0;
    int   r_cnt        = 0;
    int   checks       = 0;
    int   errors       = 0;

    sprite_scheduler_if #(.CORDW(CW), .SPR_IDW(IW)) sif ();

    sprite_scheduler #(
        .SPR_WIDTH  (8),
        .SPR_HEIGHT (8),
        .CORDW      (CW),
        .SPR_IDW    (IW),
        .QDEPTH     (4),
        .WDOG       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    assign sif.spr_drawing = rend_drawing;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Renderer model: reset by spr_rst, counts enabled cycles.
    always @(negedge clk) begin
        if (sif.spr_rst) begin
            r_cnt = 0;
            rend_drawing = 1'b0;
        end else if (sif.spr_enable) begin
            r_cnt = r_cnt + 1;
            rend_drawing = !rend_dead && (r_cnt >= 2) && (r_cnt <= 65);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int x, input int y, input int id);
        sif.req_valid = 1'b1;
        sif.req_x     = CW'(x);
        sif.req_y     = CW'(y);
        sif.req_id    = IW'(id);
        check("push_ready", sif.req_ready, 1);
        tick();
        sif.req_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        sif.frame_start = 1'b1;
        tick();
        sif.frame_start = 1'b0;
    endtask

    // Called on the cycle of the pop; follows one sprite to its IDLE return.
    // ovr_at > 0 pulses frame_start on that enabled cycle (3 = first WAIT_LO).
    task automatic expect_sprite(input int x, input int y, input int id,
                                 input bit last, input int ovr_at);
        int n;
        int en;
        n = 1;
        tick();
        while (!sif.spr_rst && n < LIM) begin
            tick();
            n++;
        end
        check("clr_wait", n, 1);
        check("clr_sx", sif.spr_sx, x);
        check("clr_sy", sif.spr_sy, y);
        check("clr_id", sif.spr_id, id);
        tick();
        check("arm_enable", sif.spr_enable, 1);
        check("arm_rst", sif.spr_rst, 0);
        en = 0;
        while (sif.spr_enable && en < LIM) begin
            en++;
            sif.frame_start = (en == ovr_at);
            tick();
        end
        sif.frame_start = 1'b0;
        check("enable_cycles", en, 66);
        check("sx_stable", sif.spr_sx, x);
        check("id_stable", sif.spr_id, id);
        check("frame_done_end", sif.frame_done, last);
    endtask

    initial begin
        rst             = 1'b1;
        sif.frame_start = 1'b0;
        sif.req_valid   = 1'b0;
        sif.req_x       = '0;
        sif.req_y       = '0;
        sif.req_id      = '0;
        tick();
        tick();

        // Reset state
        check("rst_ready", sif.req_ready, 0);
        check("rst_spr_rst", sif.spr_rst, 1);
        check("rst_enable", sif.spr_enable, 0);
        check("rst_busy", sif.busy, 0);
        check("rst_frame_done", sif.frame_done, 0);
        check("rst_overrun", sif.err_overrun, 0);
        check("rst_wdog", sif.err_wdog, 0);
        check("rst_sx", sif.spr_sx, 0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", sif.req_ready, 1);

        // Requests without a frame are held
        push(10, 20, 1);
        push(100, 50, 2);
        push(0, 0, 3);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("held_enable", sif.spr_enable, 0);
            check("held_busy", sif.busy, 0);
        end

        // Frame draws the three sprites in order, then one frame_done
        pulse_frame();
        check("frame_busy", sif.busy, 1);
        expect_sprite(10, 20, 1, 1'b0, 0);
        expect_sprite(100, 50, 2, 1'b0, 0);
        expect_sprite(0, 0, 3, 1'b1, 0);
        tick();
        check("done_once", sif.frame_done, 0);
        check("idle_busy", sif.busy, 0);

        // Fill the FIFO: fifth request must be held off
        rend_dead = 1'b1;
        sif.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sif.req_x  = CW'(2 * i + 1);
            sif.req_y  = CW'(2 * i + 2);
            sif.req_id = IW'(i + 4);
            check("fill_ready", sif.req_ready, (i < 4));
            tick();
        end
        check("full_ready", sif.req_ready, 0);
        tick();
        sif.req_valid = 1'b0;

        // Dead renderer on the first sprite: watchdog fires, next sprite runs
        pulse_frame();
        tick();
        check("wd_clr", sif.spr_rst, 1);
        check("wd_sx", sif.spr_sx, 1);
        check("wd_id", sif.spr_id, 4);
        tick();
        check("wd_arm_enable", sif.spr_enable, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("wd_wait_enable", sif.spr_enable, 1);
            check("wd_not_yet", sif.err_wdog, 0);
        end
        tick();
        check("wd_fired", sif.err_wdog, 1);
        check("wd_enable_off", sif.spr_enable, 0);
        rend_dead = 1'b0;
        expect_sprite(3, 4, 5, 1'b0, 0);
        expect_sprite(5, 6, 6, 1'b0, 0);
        expect_sprite(7, 8, 7, 1'b1, 0);
        tick();
        check("fill_done_once", sif.frame_done, 0);
        check("fill_busy", sif.busy, 0);

        // Second frame_start during WAIT_LO
        check("ovr_clear", sif.err_overrun, 0);
        push(200, 300, 10);
        pulse_frame();
        expect_sprite(200, 300, 10, 1'b1, 3);
        check("ovr_set", sif.err_overrun, 1);
        check("wdog_sticky", sif.err_wdog, 1);
        tick();
        check("ovr_no_extra_done", sif.frame_done, 0);
        check("ovr_busy", sif.busy, 0);

        // Reset in WAIT_LO of sprite 2
        push(11, 12, 1);
        push(13, 14, 2);
        push(15, 16, 3);
        pulse_frame();
        expect_sprite(11, 12, 1, 1'b0, 0);
        tick();
        check("s2_sx", sif.spr_sx, 13);
        tick();
        tick();
        tick();
        check("s2_wait_lo_enable", sif.spr_enable, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_enable", sif.spr_enable, 0);
        check("mid_rst_spr_rst", sif.spr_rst, 1);
        check("mid_rst_ready", sif.req_ready, 0);
        check("mid_rst_sx", sif.spr_sx, 0);
        check("mid_rst_id", sif.spr_id, 0);
        check("mid_rst_done", sif.frame_done, 0);
        check("mid_rst_ovr", sif.err_overrun, 0);
        check("mid_rst_wdog", sif.err_wdog, 0);
        check("mid_rst_busy", sif.busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_done", sif.frame_done, 0);
            check("post_rst_enable", sif.spr_enable, 0);
        end
        check("post_rst_ready", sif.req_ready, 1);
        pulse_frame();
        check("empty_frame_done", sif.frame_done, 1);
        tick();
        check("empty_frame_once", sif.frame_done, 0);
        check("empty_frame_busy", sif.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_scheduler.md
SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 Parameter SPR_WIDTH, default 8, sprite width in pixels; it SHALL be forwarded to the renderer instance.
REQ-002 Parameter SPR_HEIGHT, default 8, sprite height in pixels.
REQ-003 Parameter CORDW, default 10, screen coordinate width.
REQ-004 Parameter SPR_IDW, default 4, sprite-id width.
REQ-005 Parameter QDEPTH, default 4, request FIFO depth; it SHALL be a power of two and at least 2.
REQ-006 Parameter WDOG, default 4, maximum number of cycles from renderer enable to drawing rise.
REQ-007 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 frame_start  in  1  one-cycle pulse that opens a draw frame.
REQ-010 req_valid, req_ready  in/out  1 each  sprite request handshake.
REQ-011 req_x, req_y  in  CORDW each  sprite top-left screen position.
REQ-012 req_id  in  SPR_IDW  sprite index.
REQ-013 spr_rst  out  1  renderer reset.
REQ-014 spr_enable  out  1  renderer enable.
REQ-015 spr_sx, spr_sy  out  CORDW each  renderer screen position.
REQ-016 spr_id  out  SPR_IDW  selects the sprite ROM bank.
REQ-017 spr_drawing  in  1  renderer drawing flag.
REQ-018 busy  out  1  high while the FSM is not in IDLE or the frame is active.
REQ-019 frame_done  out  1  one-cycle pulse when a frame drains.
REQ-020 err_overrun, err_wdog  out  1 each  sticky error flags.

Function
REQ-021 A request SHALL be accepted on the cycle where req_valid and req_ready are both high, and req_ready SHALL equal "FIFO not full".
REQ-022 The FIFO SHALL hold x, y and id in FIFO order, and its pointers SHALL wrap modulo QDEPTH.
REQ-023 A push and a pop in the same cycle while the FIFO is full SHALL be allowed only when req_ready was high, so a full FIFO never accepts a request.
REQ-024 frame_active SHALL be set by frame_start, and a frame_start while frame_active is high SHALL be ignored and set err_overrun.
REQ-025 FSM state IDLE: when frame_active is high and the FIFO is non-empty, the FSM SHALL pop the head into spr_sx/spr_sy/spr_id and go to CLR.
REQ-026 FSM state IDLE: when frame_active is high and the FIFO is empty, the FSM SHALL pulse frame_done for one cycle and clear frame_active.
REQ-027 FSM state CLR: spr_rst SHALL be high for exactly 1 cycle, and the next state SHALL be ARM.
REQ-028 FSM state ARM: spr_enable SHALL be high, and it SHALL stay high through WAIT_HI and WAIT_LO.
REQ-029 FSM state ARM: the watchdog counter SHALL be cleared, and the next state SHALL be WAIT_HI.
REQ-030 FSM state WAIT_HI: when spr_drawing is high, the FSM SHALL go to WAIT_LO.
REQ-031 FSM state WAIT_HI: when the watchdog reaches WDOG, the FSM SHALL set err_wdog and go to IDLE, skipping the sprite.
REQ-032 FSM state WAIT_LO: when spr_drawing is low, the FSM SHALL deassert spr_enable and go to IDLE.
REQ-033 The latency from pop to the first spr_enable cycle SHALL be 2 cycles.
REQ-034 A sprite SHALL occupy SPR_WIDTH*SPR_HEIGHT drawing cycles plus at most 5 overhead cycles.
REQ-035 spr_sx, spr_sy and spr_id SHALL remain stable from CLR until the next pop.
REQ-036 Requests that arrive during an active frame SHALL be drawn in that frame if they are queued before the IDLE empty check.
REQ-037 Requests queued while no frame is active SHALL be held until the next frame_start.
REQ-038 When frame_start arrives and the FIFO is empty, frame_done SHALL pulse 1 cycle after frame_start.

Reset
REQ-039 While rst is high, the FSM SHALL go to IDLE and the FIFO SHALL be emptied, discarding all requests.
REQ-040 While rst is high, frame_active SHALL be 0, and spr_enable, frame_done and both error flags SHALL be 0.
REQ-041 While rst is high, spr_rst SHALL be 1, and spr_sx, spr_sy and spr_id SHALL be 0.
REQ-042 While rst is high, req_ready SHALL be 0; it SHALL be 1 on the first cycle after reset.
REQ-043 A reset in the middle of a sprite SHALL abort the sprite immediately, with no frame_done.

Structure
REQ-044 The FSM state enum and the request struct {x, y, id} SHALL live in the shared params package.
REQ-045 The FIFO SHALL be a single sub-module named sprite_req_fifo, parameterised by width and depth.
REQ-046 The renderer SHALL be external, connected through the spr_* ports.

Verification
REQ-047 Reset, queue 3 requests (10,20,1), (100,50,2), (0,0,3) with no frame_start -> spr_enable stays 0 and busy stays 0.
REQ-048 Pulse frame_start, with a renderer model that holds drawing high for 64 cycles -> three sprites drawn in order with matching spr_sx/spr_sy/spr_id, then exactly one frame_done.
REQ-049 Push 5 requests back-to-back with QDEPTH=4 and no frame active -> req_ready falls after the 4th push and the 5th request is held off.
REQ-050 Renderer model never raises drawing -> err_wdog set 4 cycles after ARM and the FSM advances to the next request.
REQ-051 Second frame_start during WAIT_LO -> err_overrun set and the current sprite completes normally.
REQ-052 Assert rst in WAIT_LO of sprite 2 -> spr_enable is 0 the next cycle, the FIFO is empty, and no frame_done is produced.
